// File: rtl/conv_coprocessor.sv
// rtl/conv_coprocessor.sv - 1-D convolution engine Z = X * Y over external RAMs; define CONV_SAT_EN for a saturating accumulator
module conv_coprocessor #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     dataX,
    input  logic [ADDR_WIDTH-1:0]     sizeX,
    output logic [ADDR_WIDTH-1:0]     memX_addr,
    input  logic [DATA_WIDTH-1:0]     dataY,
    input  logic [ADDR_WIDTH-1:0]     sizeY,
    output logic [ADDR_WIDTH-1:0]     memY_addr,
    output logic [2*DATA_WIDTH-1:0]   dataZ,
    output logic                      writeZ,
    output logic [ADDR_WIDTH:0]       memZ_addr,
    output logic                      busy_out,
    output logic                      done_out
);

    localparam int ZW = 2 * DATA_WIDTH;
    localparam int ZA = ADDR_WIDTH + 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CLR  = 3'd1;
    localparam logic [2:0] ADDR = 3'd2;
    localparam logic [2:0] MAC  = 3'd3;
    localparam logic [2:0] WR   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] ONE_X = 1;
    localparam logic [ZA-1:0]         ONE_Z = 1;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] lenX;
    logic [ADDR_WIDTH-1:0] lenY;
    logic [ZA-1:0]         lenZ;
    logic [ADDR_WIDTH-1:0] idxI;
    logic [ZA-1:0]         idxK;
    logic [ZW-1:0]         acc;
    logic                  termValid;

    logic [ZW-1:0]         product;
    logic [ZW-1:0]         accNext;
    logic [ZA-1:0]         nextI;
    logic [ZA-1:0]         diffK;
    logic                  inRange;
    logic                  lastI;
    logic                  lastK;
    logic                  emptyRun;

    assign product  = ZW'(dataX) * ZW'(dataY);
    assign lastI    = (idxI == lenX - ONE_X);
    assign lastK    = (idxK == lenZ - ONE_Z);
    assign emptyRun = (sizeX == '0) || (sizeY == '0);

`ifdef CONV_SAT_EN
    logic [ZW:0] sumWide;
    assign sumWide = {1'b0, acc} + {1'b0, product};

    // A carry out pins the accumulator at all-ones until the next CLR.
    always_comb begin
        accNext = acc;
        if (termValid) begin
            accNext = sumWide[ZW] ? {ZW{1'b1}} : sumWide[ZW-1:0];
        end
    end
`else
    always_comb begin
        accNext = acc;
        if (termValid) begin
            accNext = acc + product;
        end
    end
`endif

    // Index of the term that the next ADDR cycle will fetch, and its Y offset.
    always_comb begin
        nextI   = (state == MAC) ? (ZA'(idxI) + ONE_Z) : '0;
        diffK   = idxK - nextI;
        inRange = (idxK >= nextI) && (diffK < ZA'(lenY));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lenX      <= '0;
            lenY      <= '0;
            lenZ      <= '0;
            idxI      <= '0;
            idxK      <= '0;
            acc       <= '0;
            termValid <= 1'b0;
            memX_addr <= '0;
            memY_addr <= '0;
            dataZ     <= '0;
            memZ_addr <= '0;
            writeZ    <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
        end else begin
            writeZ   <= 1'b0;
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lenX <= sizeX;
                        lenY <= sizeY;
                        lenZ <= ZA'(sizeX) + ZA'(sizeY) - ONE_Z;
                        idxK <= '0;
                        if (emptyRun) begin
                            state    <= DONE;
                            done_out <= 1'b1;
                        end else begin
                            state    <= CLR;
                            busy_out <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    acc       <= '0;
                    idxI      <= '0;
                    memX_addr <= '0;
                    memY_addr <= inRange ? diffK[ADDR_WIDTH-1:0] : '0;
                    termValid <= inRange;
                    state     <= ADDR;
                end
                ADDR: begin
                    state <= MAC;
                end
                MAC: begin
                    acc <= accNext;
                    if (lastI) begin
                        dataZ     <= accNext;
                        memZ_addr <= idxK;
                        writeZ    <= 1'b1;
                        state     <= WR;
                    end else begin
                        idxI      <= nextI[ADDR_WIDTH-1:0];
                        memX_addr <= nextI[ADDR_WIDTH-1:0];
                        memY_addr <= inRange ? diffK[ADDR_WIDTH-1:0] : '0;
                        termValid <= inRange;
                        state     <= ADDR;
                    end
                end
                WR: begin
                    if (lastK) begin
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idxK  <= idxK + ONE_Z;
                        state <= CLR;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_coprocessor.sv
// tb/tb_conv_coprocessor.sv - directed bench for conv_coprocessor with a convolution/timing model
module tb_conv_coprocessor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  dataX;
    logic [4:0]  sizeX;
    logic [4:0]  memX_addr;
    logic [7:0]  dataY;
    logic [4:0]  sizeY;
    logic [4:0]  memY_addr;
    logic [15:0] dataZ;
    logic        writeZ;
    logic [5:0]  memZ_addr;
    logic        busy_out;
    logic        done_out;

    conv_coprocessor #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dataX(dataX), .sizeX(sizeX), .memX_addr(memX_addr),
        .dataY(dataY), .sizeY(sizeY), .memY_addr(memY_addr),
        .dataZ(dataZ), .writeZ(writeZ), .memZ_addr(memZ_addr),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    logic [7:0]  xs [32];
    logic [7:0]  ys [32];
    logic [15:0] zMem [64];

    always @(posedge clk) begin
        dataX <= xs[memX_addr];
        dataY <= ys[memY_addr];
        if (writeZ) zMem[memZ_addr] <= dataZ;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result: true convolution sum, then wrapped or clamped to 16 bits.
    int lsx, lsy, nZ, period, endT;
    function automatic int convZ(input int k);
        int sum = 0;
        for (int i = 0; i < lsx; i++) begin
            if (k - i >= 0 && k - i < lsy) sum += int'(xs[i]) * int'(ys[k - i]);
        end
`ifdef CONV_SAT_EN
        return (sum > 65535) ? 65535 : sum;
`else
        return sum % 65536;
`endif
    endfunction

    int cyc = 0;
    bit active = 0;
    int launchCyc, doneCyc, lastWriteCyc;
    int writeCount = 0, busyCount = 0, lastGap = 0;
    bit doneSeen = 0;

    always @(negedge clk) begin
        int t;
        bit expBusy, expWr, expDone;
        cyc++;
        if (rst) begin
            active = 0;
            check("rst_busy", busy_out, 0);
            check("rst_done", done_out, 0);
            check("rst_writeZ", writeZ, 0);
            check("rst_dataZ", dataZ, 0);
            check("rst_memZ_addr", memZ_addr, 0);
            check("rst_memX_addr", memX_addr, 0);
            check("rst_memY_addr", memY_addr, 0);
        end else begin
            if (!active && start) begin
                active = 1;
                launchCyc = cyc;
                lsx = sizeX;
                lsy = sizeY;
                nZ = (lsx == 0 || lsy == 0) ? 0 : lsx + lsy - 1;
                period = 2 * lsx + 2;
                endT = nZ * period + 1;
                writeCount = 0;
                busyCount = 0;
                doneSeen = 0;
            end
            t = active ? cyc - launchCyc : -1;
            expBusy = active && t >= 1 && t <= nZ * period;
            expWr = active && nZ > 0 && t >= period && (t % period) == 0 && t <= nZ * period;
            expDone = active && t == endT;
            check("busy_out", busy_out, expBusy);
            check("writeZ", writeZ, expWr);
            check("done_out", done_out, expDone);
            if (busy_out) busyCount++;
            if (done_out) begin
                doneSeen = 1;
                doneCyc = cyc;
            end
            if (writeZ) begin
                if (writeCount > 0) lastGap = cyc - lastWriteCyc;
                lastWriteCyc = cyc;
                writeCount++;
                if (expWr) begin
                    check("memZ_addr", memZ_addr, t / period - 1);
                    check("dataZ", dataZ, convZ(t / period - 1));
                end
            end
            if (active && t >= endT) active = 0;
        end
    end

    task automatic pulseStart();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        bit got = 0;
        for (int n = 0; n < 600 && !got; n++) begin
            @(posedge clk); #1;
            got = doneSeen;
        end
        check({name, "_done_timeout"}, got, 1);
        @(posedge clk); #2;
    endtask

    task automatic loadBasic();
        for (int i = 0; i < 32; i++) begin
            xs[i] = (i < 5) ? 8'(i + 1) : 8'd0;
            ys[i] = (i < 10) ? 8'(i + 1) : 8'd0;
        end
        sizeX = 5'd5;
        sizeY = 5'd10;
    endtask

    initial begin
        int savedCount;
        bit got;
        rst = 1'b1;
        start = 1'b0;
        sizeX = '0;
        sizeY = '0;
        for (int i = 0; i < 32; i++) begin
            xs[i] = 8'd0;
            ys[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", busy_out, 0);
        check("init_writeZ", writeZ, 0);
        check("init_dataZ", dataZ, 0);
        #1 rst = 1'b0;

        // Basic run
        loadBasic();
        pulseStart();
        waitDone("basic");
        check("basic_writes", writeCount, 14);
        check("basic_gap", lastGap, 12);
        check("basic_done_after_wr", doneCyc - lastWriteCyc, 1);
        check("basic_z0", zMem[0], 1);
        check("basic_z1", zMem[1], 4);
        check("basic_z2", zMem[2], 10);
        check("basic_z4", zMem[4], 35);
        check("basic_z9", zMem[9], 110);
        check("basic_z13", zMem[13], 50);

        // Single-tap timing
        xs[0] = 8'd3;
        ys[0] = 8'd1; ys[1] = 8'd2; ys[2] = 8'd3;
        sizeX = 5'd1;
        sizeY = 5'd3;
        pulseStart();
        waitDone("timing");
        check("timing_writes", writeCount, 3);
        check("timing_gap", lastGap, 4);
        check("timing_busy_cycles", busyCount, 12);
        check("timing_z0", zMem[0], 3);
        check("timing_z1", zMem[1], 6);
        check("timing_z2", zMem[2], 9);

        // Zero size
        sizeX = 5'd0;
        sizeY = 5'd4;
        pulseStart();
        waitDone("zero");
        check("zero_writes", writeCount, 0);
        check("zero_busy_cycles", busyCount, 0);

        // Overflow
        xs[0] = 8'd255; xs[1] = 8'd255;
        ys[0] = 8'd255; ys[1] = 8'd255;
        sizeX = 5'd2;
        sizeY = 5'd2;
        pulseStart();
        waitDone("ovf");
        check("ovf_z0", zMem[0], 65025);
`ifdef CONV_SAT_EN
        check("ovf_z1", zMem[1], 65535);
`else
        check("ovf_z1", zMem[1], 64514);
`endif
        check("ovf_z2", zMem[2], 65025);

        // Reset during the third output's MAC phase
        loadBasic();
        pulseStart();
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(posedge clk); #1;
            got = (writeCount == 2);
        end
        check("midrst_reach", got, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_busy", busy_out, 0);
        check("midrst_writeZ", writeZ, 0);
        check("midrst_dataZ", dataZ, 0);
        check("midrst_memZ_addr", memZ_addr, 0);
        check("midrst_memX_addr", memX_addr, 0);
        check("midrst_memY_addr", memY_addr, 0);
        savedCount = writeCount;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        check("midrst_no_writes", writeCount, savedCount);
        pulseStart();
        waitDone("rerun");
        check("rerun_writes", writeCount, 14);
        check("rerun_z9", zMem[9], 110);
        check("rerun_z13", zMem[13], 50);

        // Start while busy is ignored
        pulseStart();
        repeat (30) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        waitDone("busystart");
        check("busystart_writes", writeCount, 14);
        check("busystart_done_cycle", doneCyc - launchCyc, 169);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
